// File: rtl/jtag_uart_pkg.sv
// Shared JTAG-UART register map, field positions, ASCII constants and printer FSM states.
package jtag_uart_pkg;

   localparam logic ADDR_DATA = 1'b0;
   localparam logic ADDR_CTRL = 1'b1;

   localparam int unsigned WSPACE_MSB = 31;
   localparam int unsigned WSPACE_LSB = 16;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   typedef enum logic [1:0] {
      StIdle,
      StPoll,
      StGap,
      StWrite
   } state_e;

endpackage

// File: rtl/hex_ascii_enc.sv
// Combinational nibble to upper-case ASCII hex digit.
module hex_ascii_enc (
   input  logic [3:0] nib_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      if (nib_i < 4'd10) begin
         ascii_o = 8'h30 + {4'h0, nib_i};
      end else begin
         ascii_o = 8'h37 + {4'h0, nib_i};
      end
   end

endmodule

// File: rtl/jtag_uart_hex_printer.sv
// Avalon-MM master that prints each sample as upper-case hex plus CR LF on the JTAG-UART,
// writing a whole message only after the control register reports enough WSPACE.
module jtag_uart_hex_printer
   import jtag_uart_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned POLL_GAP = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_address,
   output logic              m_chipselect,
   output logic              m_read_n,
   output logic              m_write_n,
   output logic [31:0]       m_writedata,
   input  logic [31:0]       m_readdata,
   input  logic              m_waitrequest,
   output logic              busy
);

   localparam int unsigned NIB     = DATA_W / 4;
   localparam int unsigned MSG_LEN = NIB + 2;
   localparam int unsigned IdxW    = $clog2(MSG_LEN);
   localparam int unsigned GapW    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic [DATA_W-1:0] msg_q, msg_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic              s_ready_q, s_ready_d;
   logic              busy_q, busy_d;
   logic              cs_q, cs_d;
   logic              rd_n_q, rd_n_d;
   logic              wr_n_q, wr_n_d;
   logic              addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic [3:0]        nib;
   logic [7:0]        nib_ascii;
   logic [7:0]        chr;
   logic [15:0]       wspace;
   logic              unused_rdata;

   assign wspace       = m_readdata[WSPACE_MSB:WSPACE_LSB];
   assign unused_rdata = ^m_readdata[WSPACE_LSB-1:0];

   always_comb begin
      nib = '0;
      for (int unsigned i = 0; i < NIB; i++) begin
         if (idx_q == IdxW'(i)) begin
            nib = msg_q[DATA_W-1-4*i -: 4];
         end
      end
   end

   hex_ascii_enc u_enc (
      .nib_i  (nib),
      .ascii_o(nib_ascii)
   );

   always_comb begin
      if (idx_q == IdxW'(NIB)) begin
         chr = CR;
      end else if (idx_q == IdxW'(NIB + 1)) begin
         chr = LF;
      end else begin
         chr = nib_ascii;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      msg_d      = msg_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      cs_d       = cs_q;
      rd_n_d     = rd_n_q;
      wr_n_d     = wr_n_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      // s_ready_q mirrors ~hold_vld_q, so accept and drain can never coincide.
      if (s_valid && s_ready_q) begin
         hold_d     = s_data;
         hold_vld_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (hold_vld_q) begin
               msg_d      = hold_q;
               hold_vld_d = 1'b0;
               state_d    = StPoll;
               cs_d       = 1'b1;
               rd_n_d     = 1'b0;
               addr_d     = ADDR_CTRL;
            end
         end
         StPoll: begin
            if (!m_waitrequest) begin
               cs_d   = 1'b0;
               rd_n_d = 1'b1;
               if (wspace >= 16'(MSG_LEN)) begin
                  idx_d   = '0;
                  state_d = StWrite;
               end else begin
                  gap_d   = GapW'(POLL_GAP - 1);
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            if (gap_q == '0) begin
               state_d = StPoll;
               cs_d    = 1'b1;
               rd_n_d  = 1'b0;
               addr_d  = ADDR_CTRL;
            end else begin
               gap_d = gap_q - GapW'(1);
            end
         end
         StWrite: begin
            // Strobe idle for one cycle between characters, then issue the next one.
            if (!cs_q) begin
               cs_d    = 1'b1;
               wr_n_d  = 1'b0;
               addr_d  = ADDR_DATA;
               wdata_d = {24'h0, chr};
            end else if (!m_waitrequest) begin
               cs_d   = 1'b0;
               wr_n_d = 1'b1;
               if (idx_q == IdxW'(MSG_LEN - 1)) begin
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            cs_d    = 1'b0;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
         end
      endcase

      s_ready_d = ~hold_vld_d;
      busy_d    = hold_vld_d | (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         msg_q      <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         s_ready_q  <= 1'b1;
         busy_q     <= 1'b0;
         cs_q       <= 1'b0;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         addr_q     <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         msg_q      <= msg_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         cs_q       <= cs_d;
         rd_n_q     <= rd_n_d;
         wr_n_q     <= wr_n_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign busy         = busy_q;
   assign m_chipselect = cs_q;
   assign m_read_n     = rd_n_q;
   assign m_write_n    = wr_n_q;
   assign m_address    = addr_q;
   assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_jtag_uart_hex_printer.sv
// Directed bench: JTAG-UART slave model plus a character scoreboard fed at sample-drive time.
module tb_jtag_uart_hex_printer;

   localparam int unsigned DW     = 16;
   localparam int unsigned TB_GAP = 16;
   localparam int unsigned MLEN   = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        m_address;
   logic        m_chipselect;
   logic        m_read_n;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = '0;
   logic        m_waitrequest = 1'b1;
   logic        busy;

   jtag_uart_hex_printer #(
      .DATA_W  (DW),
      .POLL_GAP(TB_GAP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_read_n     (m_read_n),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .m_waitrequest(m_waitrequest),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] ws_q[$];

   int reads = 0, writes = 0, wr_idx = 0, long_wr = 0;
   int cnt = 0, stall = 1, rd_done_cyc = 0;
   int last_ws = 0;
   logic prev_short = 1'b0;
   logic act = 1'b0;
   logic snap_addr, snap_rd, snap_wr;
   logic [31:0] snap_wd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_msg(input logic [15:0] v);
      string hexd = "0123456789ABCDEF";
      for (int i = 0; i < 4; i++) begin
         logic [3:0] nb;
         nb = v[15-4*i -: 4];
         exp_q.push_back(hexd[int'(nb)]);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Slave model: decides waitrequest on the falling edge for the next rising edge.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_waitrequest = 1'b1;
         act = 1'b0;
         cnt = 0;
         prev_short = 1'b0;
      end else if (!m_waitrequest) begin
         m_waitrequest = 1'b1;
         act = 1'b0;
      end else if (m_chipselect) begin
         if (!act) begin
            act = 1'b1;
            cnt = 0;
            snap_addr = m_address;
            snap_rd = m_read_n;
            snap_wr = m_write_n;
            snap_wd = m_writedata;
            if (!m_write_n) begin
               wr_idx++;
               stall = (wr_idx == long_wr) ? 10 : 1;
            end else begin
               stall = 1;
               if (prev_short) check("poll_gap", 32'(cyc - rd_done_cyc), 32'(TB_GAP));
            end
         end else begin
            check("stable_addr", 32'(m_address), 32'(snap_addr));
            check("stable_rd_n", 32'(m_read_n), 32'(snap_rd));
            check("stable_wr_n", 32'(m_write_n), 32'(snap_wr));
            check("stable_wdata", m_writedata, snap_wd);
         end
         if (cnt >= stall) begin
            m_waitrequest = 1'b0;
            if (!m_read_n) begin
               logic [15:0] ws;
               ws = (ws_q.size() > 0) ? ws_q.pop_front() : 16'd64;
               m_readdata = {ws, 16'h0};
               reads++;
               last_ws = int'(ws);
               rd_done_cyc = cyc + 1;
               prev_short = (int'(ws) < MLEN);
               check("read_addr", 32'(m_address), 32'd1);
            end else begin
               writes++;
               check("write_addr", 32'(m_address), 32'd0);
               check("write_after_space", 32'(last_ws >= MLEN), 32'd1);
               if (exp_q.size() == 0) begin
                  check("unexpected_char", m_writedata, 32'hFFFF_FFFF);
               end else begin
                  check("char", m_writedata, {24'h0, exp_q.pop_front()});
               end
            end
         end else begin
            cnt++;
         end
      end
   end

   task automatic send(input logic [15:0] v);
      int n;
      push_msg(v);
      s_data = v;
      s_valid = 1'b1;
      n = 0;
      while (s_ready !== 1'b1 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("accept_timeout", 32'(n < 5000), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_timeout", 32'(n < 5000), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
      check({tag, "_cs"}, 32'(m_chipselect), 32'd0);
      check({tag, "_read_n"}, 32'(m_read_n), 32'd1);
      check({tag, "_write_n"}, 32'(m_write_n), 32'd1);
      check({tag, "_addr"}, 32'(m_address), 32'd0);
      check({tag, "_wdata"}, m_writedata, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int base;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1: single sample
      reads = 0; writes = 0; wr_idx = 0;
      send(16'h1A2F);
      s_valid = 1'b0;
      wait_done();
      check("t1_reads", 32'(reads), 32'd1);
      check("t1_writes", 32'(writes), 32'd6);

      // T2: back-pressure, three short polls
      reads = 0; writes = 0; wr_idx = 0;
      ws_q.push_back(16'd3); ws_q.push_back(16'd3); ws_q.push_back(16'd3);
      send(16'hC0DE);
      s_valid = 1'b0;
      wait_done();
      check("t2_reads", 32'(reads), 32'd4);
      check("t2_writes", 32'(writes), 32'd6);

      // T3: long stall on the 3rd write
      reads = 0; writes = 0; wr_idx = 0; long_wr = 3;
      send(16'h5A5A);
      s_valid = 1'b0;
      wait_done();
      long_wr = 0;
      check("t3_writes", 32'(writes), 32'd6);

      // T4: streaming with s_valid held high
      reads = 0; writes = 0; wr_idx = 0;
      send(16'h0000);
      base = writes;
      send(16'hFFFF);
      check("t4_overlap", 32'(writes - base < 6), 32'd1);
      check("t4_ready_low", 32'(s_ready), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
      send(16'h0009);
      s_valid = 1'b0;
      wait_done();
      check("t4_writes", 32'(writes), 32'd18);

      // T6: WSPACE boundary, exactly MSG_LEN then one short
      reads = 0; writes = 0; wr_idx = 0;
      ws_q.push_back(16'd6);
      send(16'h1234);
      s_valid = 1'b0;
      wait_done();
      check("t6_eq_reads", 32'(reads), 32'd1);
      reads = 0;
      ws_q.push_back(16'd5);
      send(16'hABCD);
      s_valid = 1'b0;
      wait_done();
      check("t6_short_reads", 32'(reads), 32'd2);

      // T5: reset during the 4th write
      reads = 0; writes = 0; wr_idx = 0;
      send(16'h7777);
      s_valid = 1'b0;
      n = 0;
      while (wr_idx < 4 && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("t5_reach", 32'(n < 2000), 32'd1);
      check("t5_in_write", 32'(m_write_n), 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_reset");
      exp_q.delete();
      ws_q.delete();
      last_ws = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      writes = 0;
      send(16'hBEEF);
      s_valid = 1'b0;
      wait_done();
      check("t5_writes", 32'(writes), 32'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
